piece_fall_engine: RTL and testbench

//  Parametrised falling-piece engine for the Tetris VGA datapath. Owns a COLS x ROWS

---
 rtl/tetris_pkg.sv | 39 +++
 rtl/piece_fall_engine_if.sv | 25 ++
 rtl/piece_shape_rom.sv | 45 ++++
 rtl/piece_fall_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_piece_fall_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared key codes, FSM encoding, piece codes and shape packing for the Tetris
// falling-piece datapath.
package tetris_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h6b;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ROT   = 8'h75;

  typedef enum logic [1:0] {
    ST_SPAWN = 2'd0,
    ST_FALL  = 2'd1,
    ST_LOCK  = 2'd2,
    ST_OVER  = 2'd3
  } fsm_state_t;

  typedef enum logic [2:0] {
    PC_O  = 3'd0,
    PC_I  = 3'd1,
    PC_T  = 3'd2,
    PC_L  = 3'd3,
    PC_J  = 3'd4,
    PC_S  = 3'd5,
    PC_Z  = 3'd6,
    PC_O2 = 3'd7
  } piece_t;

  // Four cells of a piece; each nibble is {dx[1:0], dy[1:0]} from the origin.
  typedef logic [3:0][3:0] shape_t;

  function automatic logic [1:0] cell_dx(input shape_t s, input logic [1:0] i);
    return s[i][3:2];
  endfunction

  function automatic logic [1:0] cell_dy(input shape_t s, input logic [1:0] i);
    return s[i][1:0];
  endfunction

endpackage

// File: rtl/piece_fall_engine_if.sv
// Key/query/status bundle between the PS/2 + VGA front end and the falling-piece engine.
interface piece_fall_engine_if;
  logic [7:0]  key_in;
  logic        key_en;
  logic [12:0] rand_in;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        en_inner;
  logic        en_edge;
  logic [9:0]  ref_x;
  logic [9:0]  ref_y;
  logic [2:0]  piece_type;
  logic        lock_pulse;
  logic        game_over;

  modport master (
    output key_in, key_en, rand_in, pix_x, pix_y,
    input  en_inner, en_edge, ref_x, ref_y, piece_type, lock_pulse, game_over
  );

  modport slave (
    input  key_in, key_en, rand_in, pix_x, pix_y,
    output en_inner, en_edge, ref_x, ref_y, piece_type, lock_pulse, game_over
  );
endinterface

// File: rtl/piece_shape_rom.sv
// Combinational shape table: (type, rotation) -> four {dx,dy} cells, every shape
// anchored so its leftmost column and top row sit at offset 0.
module piece_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0] ptype,
  input  logic [1:0] rot,
  output shape_t     cells
);

  always_comb begin
    cells = 16'h0415;
    case (piece_t'(ptype))
      PC_I: cells = rot[0] ? 16'h0123 : 16'h048C;
      PC_T: begin
        case (rot)
          2'd0: cells = 16'h0485;
          2'd1: cells = 16'h4156;
          2'd2: cells = 16'h4159;
          2'd3: cells = 16'h0152;
        endcase
      end
      PC_L: begin
        case (rot)
          2'd0: cells = 16'h0126;
          2'd1: cells = 16'h0481;
          2'd2: cells = 16'h0456;
          2'd3: cells = 16'h8159;
        endcase
      end
      PC_J: begin
        case (rot)
          2'd0: cells = 16'h4526;
          2'd1: cells = 16'h0159;
          2'd2: cells = 16'h0412;
          2'd3: cells = 16'h0489;
        endcase
      end
      PC_S: cells = rot[0] ? 16'h0156 : 16'h4815;
      PC_Z: cells = rot[0] ? 16'h4152 : 16'h0459;
      default: cells = 16'h0415;
    endcase
  end

endmodule

// File: rtl/piece_fall_engine.sv
// Falling-piece engine: occupancy board, active pose, gravity, key moves with
// collision checking, lock/spawn, and a registered per-pixel cell query.
module piece_fall_engine
  import tetris_pkg::*;
#(
  parameter int CELL_SIZE = 16,
  parameter int COLS      = 10,
  parameter int ROWS      = 30,
  parameter int X_MIN     = 240,
  parameter int SPAWN_COL = 4,
  parameter int TICK_DIV  = 10000000,
  parameter int NUM_TYPES = 5
) (
  input  logic                iVGA_CLK,
  input  logic                iRST,
  piece_fall_engine_if.slave  bus
);

  localparam int SH    = $clog2(CELL_SIZE);
  localparam int QW    = 10 - SH;
  localparam int POS_W = $clog2(((COLS > ROWS) ? COLS : ROWS) + 4) + 1;
  localparam int NCELL = COLS * ROWS;
  localparam int IDX_W = $clog2(NCELL);
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t          COLS_P    = pos_t'(COLS);
  localparam pos_t          ROWS_P    = pos_t'(ROWS);
  localparam pos_t          SPAWN_P   = pos_t'(SPAWN_COL);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [9:0]    X_MIN_P   = 10'(X_MIN);

  fsm_state_t       state, state_n;
  logic [2:0]       cur_type, cand_type, type_n;
  logic [1:0]       cur_rot, cand_rot, rot_n;
  pos_t             cur_col, cand_col, col_n;
  pos_t             cur_row, cand_row, row_n;
  logic [NCELL-1:0] board, board_n, lock_mask;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic             cand_req, cand_down, cand_blocked;
  logic             lock_pulse_q, lock_pulse_n;
  logic             game_over_q, game_over_n;
  shape_t           cur_cells, cand_cells;

  piece_shape_rom u_rom_cur  (.ptype(cur_type),  .rot(cur_rot),  .cells(cur_cells));
  piece_shape_rom u_rom_cand (.ptype(cand_type), .rot(cand_rot), .cells(cand_cells));

  function automatic pos_t cell_x(input pos_t org, input shape_t s, input logic [1:0] i);
    return org + pos_t'(cell_dx(s, i));
  endfunction

  function automatic pos_t cell_y(input pos_t org, input shape_t s, input logic [1:0] i);
    return org + pos_t'(cell_dy(s, i));
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input pos_t cx, input pos_t cy);
    return IDX_W'(cy) * IDX_W'(COLS) + IDX_W'(cx);
  endfunction

  function automatic logic cell_blocked(input pos_t cx, input pos_t cy,
                                        input logic [NCELL-1:0] brd);
    if (cx[POS_W-1] || (cx >= COLS_P) || (cy >= ROWS_P)) return 1'b1;
    return brd[cell_idx(cx, cy)];
  endfunction

  assign tick = (tick_cnt == TICK_LAST);

  // Candidate pose: spawn pose, or the current pose with at most one change.
  always_comb begin
    cand_type = cur_type;
    cand_rot  = cur_rot;
    cand_col  = cur_col;
    cand_row  = cur_row;
    cand_req  = 1'b0;
    cand_down = 1'b0;
    case (state)
      ST_SPAWN: begin
        cand_type = 3'(bus.rand_in % 13'(NUM_TYPES));
        cand_rot  = 2'd0;
        cand_col  = SPAWN_P;
        cand_row  = '0;
        cand_req  = 1'b1;
      end
      ST_FALL: begin
        if (tick) begin
          cand_row  = cur_row + pos_t'(1);
          cand_req  = 1'b1;
          cand_down = 1'b1;
        end else if (bus.key_en) begin
          cand_req = 1'b1;
          case (bus.key_in)
            KEY_DOWN: begin
              cand_row  = cur_row + pos_t'(1);
              cand_down = 1'b1;
            end
            KEY_LEFT:  cand_col = cur_col - pos_t'(1);
            KEY_RIGHT: cand_col = cur_col + pos_t'(1);
            KEY_ROT:   cand_rot = cur_rot + 2'd1;
            default:   cand_req = 1'b0;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cand_blocked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cell_blocked(cell_x(cand_col, cand_cells, 2'(i)),
                       cell_y(cand_row, cand_cells, 2'(i)), board))
        cand_blocked = 1'b1;
    end
  end

  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < 4; i++)
      lock_mask[cell_idx(cell_x(cur_col, cur_cells, 2'(i)),
                         cell_y(cur_row, cur_cells, 2'(i)))] = 1'b1;
  end

  always_comb begin
    state_n      = state;
    type_n       = cur_type;
    rot_n        = cur_rot;
    col_n        = cur_col;
    row_n        = cur_row;
    board_n      = board;
    lock_pulse_n = 1'b0;
    game_over_n  = game_over_q;
    case (state)
      ST_SPAWN: begin
        type_n = cand_type;
        rot_n  = cand_rot;
        col_n  = cand_col;
        row_n  = cand_row;
        if (cand_blocked) begin
          state_n     = ST_OVER;
          game_over_n = 1'b1;
        end else begin
          state_n = ST_FALL;
        end
      end
      ST_FALL: begin
        if (cand_req) begin
          if (!cand_blocked) begin
            rot_n = cand_rot;
            col_n = cand_col;
            row_n = cand_row;
          end else if (cand_down) begin
            state_n = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        board_n      = board | lock_mask;
        lock_pulse_n = 1'b1;
        state_n      = ST_SPAWN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) state <= ST_SPAWN;
    else      state <= state_n;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      cur_type     <= 3'd0;
      cur_rot      <= 2'd0;
      cur_col      <= SPAWN_P;
      cur_row      <= '0;
      board        <= '0;
      lock_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
      tick_cnt     <= '0;
    end else begin
      cur_type     <= type_n;
      cur_rot      <= rot_n;
      cur_col      <= col_n;
      cur_row      <= row_n;
      board        <= board_n;
      lock_pulse_q <= lock_pulse_n;
      game_over_q  <= game_over_n;
      if (state != ST_OVER)
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // Query stage p0: decode pixel to cell and decide hit/border.
  logic [9:0]    off_x_p0;
  logic [QW-1:0] qc_p0, qr_p0;
  pos_t          qcol_p0, qrow_p0;
  logic          in_field_p0, hit_p0, edge_p0;
  logic          en_inner_p1, en_edge_p1;

  always_comb begin
    off_x_p0    = bus.pix_x - X_MIN_P;
    qc_p0       = off_x_p0[9:SH];
    qr_p0       = bus.pix_y[9:SH];
    qcol_p0     = pos_t'(qc_p0);
    qrow_p0     = pos_t'(qr_p0);
    in_field_p0 = (bus.pix_x >= X_MIN_P) && (qc_p0 < QW'(COLS)) && (qr_p0 < QW'(ROWS));
    hit_p0      = 1'b0;
    if (in_field_p0) begin
      hit_p0 = board[cell_idx(qcol_p0, qrow_p0)];
      if (state == ST_FALL || state == ST_LOCK) begin
        for (int i = 0; i < 4; i++) begin
          if (cell_x(cur_col, cur_cells, 2'(i)) == qcol_p0 &&
              cell_y(cur_row, cur_cells, 2'(i)) == qrow_p0)
            hit_p0 = 1'b1;
        end
      end
    end
    edge_p0 = (off_x_p0[SH-1:0] == '0) || (&off_x_p0[SH-1:0]) ||
              (bus.pix_y[SH-1:0] == '0) || (&bus.pix_y[SH-1:0]);
  end

  // Query stage p1: registered enables for the colour muxes.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      en_inner_p1 <= 1'b0;
      en_edge_p1  <= 1'b0;
    end else begin
      en_inner_p1 <= hit_p0 && !edge_p0;
      en_edge_p1  <= hit_p0 && edge_p0;
    end
  end

  assign bus.en_inner   = en_inner_p1;
  assign bus.en_edge    = en_edge_p1;
  assign bus.ref_x      = X_MIN_P + (10'(cur_col) << SH);
  assign bus.ref_y      = 10'(cur_row) << SH;
  assign bus.piece_type = cur_type;
  assign bus.lock_pulse = lock_pulse_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_piece_fall_engine.sv
// Bench for piece_fall_engine: directed scenario steps followed by randomized keys,
// spawn values and pixel queries, all scored against a board/pose model.
module tb_piece_fall_engine;

  localparam int TD   = 8;
  localparam int NCOL = 10;
  localparam int NROW = 30;
  localparam int XM   = 240;
  localparam int CS   = 16;
  localparam int SPC  = 4;
  localparam int NT   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  piece_fall_engine_if bus ();

  piece_fall_engine #(
    .CELL_SIZE(CS), .COLS(NCOL), .ROWS(NROW), .X_MIN(XM),
    .SPAWN_COL(SPC), .TICK_DIV(TD), .NUM_TYPES(NT)
  ) dut (
    .iVGA_CLK(clk),
    .iRST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Cell list per (type, rotation): dx0,dy0, dx1,dy1, dx2,dy2, dx3,dy3
  int shape_tbl [NT][4][8] = '{
    '{ '{0,0,1,0,0,1,1,1}, '{0,0,1,0,0,1,1,1}, '{0,0,1,0,0,1,1,1}, '{0,0,1,0,0,1,1,1} },
    '{ '{0,0,1,0,2,0,3,0}, '{0,0,0,1,0,2,0,3}, '{0,0,1,0,2,0,3,0}, '{0,0,0,1,0,2,0,3} },
    '{ '{0,0,1,0,2,0,1,1}, '{1,0,0,1,1,1,1,2}, '{1,0,0,1,1,1,2,1}, '{0,0,0,1,1,1,0,2} },
    '{ '{0,0,0,1,0,2,1,2}, '{0,0,1,0,2,0,0,1}, '{0,0,1,0,1,1,1,2}, '{2,0,0,1,1,1,2,1} },
    '{ '{1,0,1,1,0,2,1,2}, '{0,0,0,1,1,1,2,1}, '{0,0,1,0,0,1,0,2}, '{0,0,1,0,2,0,2,1} }
  };

  bit m_board [NROW][NCOL];
  int m_phase;  // 0 spawning, 1 falling, 2 locking, 3 game over
  int m_type, m_rot, m_col, m_row, m_cnt;
  bit m_lp, m_go, m_ein, m_eedge;

  int nvec = 0;
  int nerr = 0;

  function automatic bit fits(int t, int r, int c, int row);
    int cx, cy;
    for (int i = 0; i < 4; i++) begin
      cx = c + shape_tbl[t][r][2*i];
      cy = row + shape_tbl[t][r][2*i+1];
      if (cx < 0 || cx >= NCOL || cy >= NROW) return 1'b0;
      if (m_board[cy][cx]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit is_active(int qc, int qr);
    if (m_phase != 1 && m_phase != 2) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_col + shape_tbl[m_type][m_rot][2*i] == qc &&
          m_row + shape_tbl[m_type][m_rot][2*i+1] == qr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_query(input int px, input int py, output bit ein, output bit eedge);
    int qc, qr, ox, oy;
    bit hit, bord;
    ein = 1'b0;
    eedge = 1'b0;
    if (px < XM) return;
    qc = (px - XM) / CS;
    qr = py / CS;
    if (qc >= NCOL || qr >= NROW) return;
    hit = m_board[qr][qc] || is_active(qc, qr);
    ox = (px - XM) % CS;
    oy = py % CS;
    bord = (ox == 0) || (ox == CS - 1) || (oy == 0) || (oy == CS - 1);
    ein = hit && !bord;
    eedge = hit && bord;
  endtask

  task automatic model_step(input bit r, input bit ken, input logic [7:0] k, input logic [12:0] rnd);
    bit tk, req;
    int dc, dr, drot;
    if (r) begin
      for (int y = 0; y < NROW; y++)
        for (int x = 0; x < NCOL; x++) m_board[y][x] = 1'b0;
      m_phase = 0; m_type = 0; m_rot = 0; m_col = SPC; m_row = 0; m_cnt = 0;
      m_lp = 1'b0; m_go = 1'b0;
      return;
    end
    m_lp = 1'b0;
    tk = (m_cnt == TD - 1);
    if (m_phase != 3) m_cnt = (m_cnt + 1) % TD;
    case (m_phase)
      0: begin
        m_type = int'(rnd) % NT; m_rot = 0; m_col = SPC; m_row = 0;
        if (fits(m_type, 0, SPC, 0)) m_phase = 1;
        else begin m_phase = 3; m_go = 1'b1; end
      end
      1: begin
        dc = 0; dr = 0; drot = 0; req = 1'b0;
        if (tk) begin dr = 1; req = 1'b1; end
        else if (ken) begin
          req = 1'b1;
          case (k)
            8'h72:   dr = 1;
            8'h6b:   dc = -1;
            8'h74:   dc = 1;
            8'h75:   drot = 1;
            default: req = 1'b0;
          endcase
        end
        if (req) begin
          if (fits(m_type, (m_rot + drot) % 4, m_col + dc, m_row + dr)) begin
            m_col = m_col + dc; m_row = m_row + dr; m_rot = (m_rot + drot) % 4;
          end else if (dr != 0) m_phase = 2;
        end
      end
      2: begin
        for (int i = 0; i < 4; i++)
          m_board[m_row + shape_tbl[m_type][m_rot][2*i+1]][m_col + shape_tbl[m_type][m_rot][2*i]] = 1'b1;
        m_lp = 1'b1;
        m_phase = 0;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ken, input logic [7:0] k,
                      input logic [12:0] rnd, input int px, input int py);
    bit qi, qe;
    rst = r;
    bus.key_en = ken;
    bus.key_in = k;
    bus.rand_in = rnd;
    bus.pix_x = 10'(px);
    bus.pix_y = 10'(py);
    model_query(px, py, qi, qe);
    if (r) begin qi = 1'b0; qe = 1'b0; end
    @(posedge clk);
    model_step(r, ken, k, rnd);
    m_ein = qi;
    m_eedge = qe;
    #1;
    chk("ref_x",      32'(bus.ref_x),      32'(XM + m_col * CS));
    chk("ref_y",      32'(bus.ref_y),      32'(m_row * CS));
    chk("piece_type", 32'(bus.piece_type), 32'(m_type));
    chk("lock_pulse", 32'(bus.lock_pulse), 32'(m_lp));
    chk("game_over",  32'(bus.game_over),  32'(m_go));
    chk("en_inner",   32'(bus.en_inner),   32'(m_ein));
    chk("en_edge",    32'(bus.en_edge),    32'(m_eedge));
  endtask

  function automatic int rpx();
    return int'($urandom_range(420, 200));
  endfunction

  function automatic int rpy();
    return int'($urandom_range(499, 0));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 13'd0, rpx(), rpy());
  endtask

  task automatic keys(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, k, 13'd0, rpx(), rpy());
  endtask

  initial begin
    int ry, rx, guard;
    logic [7:0] kc;
    bus.key_en = 1'b0; bus.key_in = 8'h00; bus.rand_in = 13'd0;
    bus.pix_x = 10'd0; bus.pix_y = 10'd0;

    // Reset, spawn, and gravity timing
    step(1'b1, 1'b0, 8'h00, 13'd0, rpx(), rpy());
    chk("rst_ref_x", 32'(bus.ref_x), 32'd304);
    chk("rst_ref_y", 32'(bus.ref_y), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    chk("rst_en_inner", 32'(bus.en_inner), 32'd0);
    idle(7);
    chk("pre_tick_ref_y", 32'(bus.ref_y), 32'd0);
    idle(1);
    chk("tick1_ref_y", 32'(bus.ref_y), 32'd16);
    idle(8);
    chk("tick2_ref_y", 32'(bus.ref_y), 32'd32);

    // Left/right clamping at the walls
    keys(8'h6b, 7);
    chk("left_clamp", 32'(bus.ref_x), 32'd240);
    keys(8'h6b, 2);
    chk("left_hold", 32'(bus.ref_x), 32'd240);
    keys(8'h74, 12);
    chk("right_clamp", 32'(bus.ref_x), 32'd368);
    keys(8'h74, 2);
    chk("right_hold", 32'(bus.ref_x), 32'd368);

    // Down key coinciding with a tick advances one row only
    guard = 0;
    while (m_cnt != TD - 1 && guard < TD) begin idle(1); guard++; end
    ry = int'(bus.ref_y);
    keys(8'h72, 1);
    chk("tick_plus_down", 32'(bus.ref_y), 32'(ry + 16));

    // Fall to the floor and lock
    guard = 0;
    while (!bus.lock_pulse && guard < 400) begin idle(1); guard++; end
    chk("lock_seen", 32'(bus.lock_pulse), 32'd1);
    idle(1);
    chk("lock_one_cycle", 32'(bus.lock_pulse), 32'd0);
    chk("respawn_row", 32'(bus.ref_y), 32'd0);
    step(1'b0, 1'b0, 8'h00, 13'd0, 240 + 8*16 + 5, 28*16 + 5);
    chk("locked_inner", 32'(bus.en_inner), 32'd1);
    step(1'b0, 1'b0, 8'h00, 13'd0, 240 + 8*16, 28*16 + 5);
    chk("locked_edge", 32'(bus.en_edge), 32'd1);
    chk("locked_edge_not_inner", 32'(bus.en_inner), 32'd0);
    step(1'b0, 1'b0, 8'h00, 13'd0, 239, 28*16 + 5);
    chk("left_of_field", 32'(bus.en_edge | bus.en_inner), 32'd0);
    step(1'b0, 1'b0, 8'h00, 13'd0, 240 + 10*16 + 5, 28*16 + 5);
    chk("right_of_field", 32'(bus.en_edge | bus.en_inner), 32'd0);

    // Stack the spawn column until a spawn collides
    guard = 0;
    while (!bus.game_over && guard < 4000) begin idle(1); guard++; end
    chk("game_over_set", 32'(bus.game_over), 32'd1);
    rx = int'(bus.ref_x);
    ry = int'(bus.ref_y);
    for (int i = 0; i < 12; i++) begin
      kc = (i % 2 == 0) ? 8'h72 : 8'h6b;
      step(1'b0, 1'b1, kc, 13'($urandom), rpx(), rpy());
    end
    chk("over_frozen_x", 32'(bus.ref_x), 32'(rx));
    chk("over_frozen_y", 32'(bus.ref_y), 32'(ry));
    step(1'b1, 1'b0, 8'h00, 13'd0, rpx(), rpy());
    chk("rst_clears_over", 32'(bus.game_over), 32'd0);
    idle(1);
    step(1'b0, 1'b0, 8'h00, 13'd0, 240 + 8*16 + 5, 28*16 + 5);
    chk("board_cleared", 32'(bus.en_inner), 32'd0);

    // Randomized keys, spawn values, queries and occasional resets
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(5, 0))
        0: kc = 8'h72;
        1: kc = 8'h6b;
        2: kc = 8'h74;
        3: kc = 8'h75;
        4: kc = 8'h75;
        default: kc = 8'($urandom);
      endcase
      step(($urandom_range(399, 0) == 0), ($urandom_range(1, 0) == 1), kc,
           13'($urandom), rpx(), rpy());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
